// File: rtl/lockin_sched_pkg.sv
// lockin_sched_pkg
// Shared definitions for the lock-in MAC scheduler: default sizing,
// FSM state encodings and a helper that pulls one channel's tap count
// out of the packed per-channel tap vector.
package lockin_sched_pkg;

  localparam int NUM_CH_DEF      = 5;
  localparam int TAP_W_DEF       = 7;
  localparam int MAC_LATENCY_DEF = 2;
  localparam int CYC_W_DEF       = 16;

  // Widest packed tap vector and widest tap count the helper handles.
  localparam int TAP_VEC_MAX = 1024;
  localparam int TAP_CNT_MAX = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ARB   = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Channel ch occupies bits [ch*w +: w] of vec.
  function automatic logic [TAP_CNT_MAX-1:0] tap_count(
    input logic [TAP_VEC_MAX-1:0] vec,
    input int unsigned            ch,
    input int unsigned            w
  );
    logic [TAP_VEC_MAX-1:0] shifted;
    logic [TAP_CNT_MAX-1:0] mask;
    shifted = vec >> (ch * w);
    mask    = (w >= TAP_CNT_MAX) ? '1 : ((TAP_CNT_MAX'(1) << w) - TAP_CNT_MAX'(1));
    return shifted[TAP_CNT_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/lockin_mac_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: first set request at or after ptr,
// wrapping around to channel 0.
// Ports:
//   req   - request vector
//   ptr   - starting channel for the search
//   grant - one-hot winner (zero if no request)
//   idx   - binary index of the winner
//   valid - any request present
module rr_arbiter
  import lockin_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = 3
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx,
  output logic              valid
);

  // Two passes: the upper segment starting at ptr, then the wrap-around.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!valid && req[k] && (k >= int'(ptr))) begin
        valid    = 1'b1;
        grant[k] = 1'b1;
        idx      = CH_W'(k);
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (!valid && req[k]) begin
        valid    = 1'b1;
        grant[k] = 1'b1;
        idx      = CH_W'(k);
      end
    end
  end

endmodule

// File: rtl/lockin_mac_scheduler.sv
// lockin_mac_scheduler
// Time-shares one MAC engine among the lock-in FIR stages. Each sample
// tick latches the channels that need service; they are granted in
// round-robin order, tap indices are streamed one per cycle framed by
// clear/last, and a per-channel done pulses once the MAC pipeline drains.
// Ports:
//   clk_i, reset_ni        - clock, async active-low reset
//   tick_i, en_i           - sample strobe and per-channel enables
//   taps_i                 - packed per-channel tap counts
//   grant_o                - one-hot channel owning the MAC
//   tap_idx_o, mac_valid_o - tap index and its valid
//   mac_clear_o/mac_last_o - first / final tap of a channel
//   done_o                 - per-channel result-valid pulse
//   busy_o, overrun_o      - activity and sticky overrun flag
//   max_cycles_o           - longest busy period (LOCKIN_SCHED_STATS_EN only)
// Optional feature macro: LOCKIN_SCHED_STATS_EN
module lockin_mac_scheduler
  import lockin_sched_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int TAP_W       = TAP_W_DEF,
  parameter int MAC_LATENCY = MAC_LATENCY_DEF
`ifdef LOCKIN_SCHED_STATS_EN
  , parameter int CYC_W     = CYC_W_DEF
`endif
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    tick_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*TAP_W-1:0] taps_i,
  output logic [NUM_CH-1:0]       grant_o,
  output logic [TAP_W-1:0]        tap_idx_o,
  output logic                    mac_valid_o,
  output logic                    mac_clear_o,
  output logic                    mac_last_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic                    busy_o,
  output logic                    overrun_o
`ifdef LOCKIN_SCHED_STATS_EN
  , output logic [CYC_W-1:0]      max_cycles_o
`endif
);

  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    (MAC_LATENCY > 0) ? DRAIN_W'(MAC_LATENCY - 1) : '0;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  state_t              state;
  logic [NUM_CH-1:0]   pending;
  logic [CH_W-1:0]     ptr;
  logic [CH_W-1:0]     ch;
  logic [TAP_W-1:0]    idx;
  logic [DRAIN_W-1:0]  drain_cnt;

  logic [NUM_CH-1:0]   arb_grant;
  logic [CH_W-1:0]     arb_idx;
  logic                arb_valid;
  logic [NUM_CH-1:0]   tick_req;
  logic [NUM_CH-1:0]   pending_next;
  logic [NUM_CH-1:0]   ch_onehot;
  logic [TAP_W-1:0]    run_taps;
  logic [TAP_W-1:0]    arb_taps;
  logic                last_tap;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req   (pending),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign tick_req     = tick_i ? en_i : '0;
  assign pending_next = pending | tick_req;
  assign ch_onehot    = NUM_CH'(1) << ch;
  assign run_taps     = TAP_W'(tap_count(TAP_VEC_MAX'(taps_i), 32'(ch), TAP_W));
  assign arb_taps     = TAP_W'(tap_count(TAP_VEC_MAX'(taps_i), 32'(arb_idx), TAP_W));
  assign last_tap     = (idx == (run_taps - TAP_W'(1)));
  assign busy_o       = (state != ST_IDLE) || (pending != '0);

  // IDLE and DONE look at pending_next so a tick in the same cycle is
  // already visible to the following ARB. The ARB clear only removes the
  // old bit, so a fresh tick for the granted channel stays queued.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= ST_IDLE;
      pending   <= '0;
      ptr       <= '0;
      ch        <= '0;
      idx       <= '0;
      drain_cnt <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (tick_i && busy_o) overrun_o <= 1'b1;
      pending <= pending_next;
      case (state)
        ST_IDLE: begin
          if (pending_next != '0) state <= ST_ARB;
        end
        ST_ARB: begin
          if (arb_valid) begin
            ch      <= arb_idx;
            pending <= (pending & ~arb_grant) | tick_req;
            ptr     <= (arb_idx == CH_LAST) ? '0 : arb_idx + CH_W'(1);
            idx     <= '0;
            state   <= (arb_taps == '0) ? ST_DONE : ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (last_tap) begin
            idx       <= '0;
            drain_cnt <= '0;
            state     <= (MAC_LATENCY == 0) ? ST_DONE : ST_DRAIN;
          end else begin
            idx <= idx + TAP_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= ST_DONE;
          else drain_cnt <= drain_cnt + DRAIN_W'(1);
        end
        ST_DONE: begin
          state <= (pending_next != '0) ? ST_ARB : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // During ARB the latched channel is not yet valid, so the grant comes
  // straight from the arbiter.
  always_comb begin
    grant_o     = '0;
    done_o      = '0;
    tap_idx_o   = '0;
    mac_valid_o = 1'b0;
    mac_clear_o = 1'b0;
    mac_last_o  = 1'b0;
    case (state)
      ST_ARB: grant_o = arb_grant;
      ST_RUN: begin
        grant_o     = ch_onehot;
        mac_valid_o = 1'b1;
        tap_idx_o   = idx;
        mac_clear_o = (idx == '0);
        mac_last_o  = last_tap;
      end
      ST_DRAIN: grant_o = ch_onehot;
      ST_DONE: begin
        grant_o = ch_onehot;
        done_o  = ch_onehot;
      end
      default: ;
    endcase
  end

`ifdef LOCKIN_SCHED_STATS_EN
  logic [CYC_W-1:0] cyc_cnt;
  logic             busy_q;

  // The counter restarts on a tick from idle and saturates; its value is
  // folded into the maximum on the cycle busy drops.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cyc_cnt      <= '0;
      busy_q       <= 1'b0;
      max_cycles_o <= '0;
    end else begin
      busy_q <= busy_o;
      if (tick_i && !busy_o) cyc_cnt <= CYC_W'(1);
      else if (busy_o && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + CYC_W'(1);
      if (busy_q && !busy_o && (cyc_cnt > max_cycles_o)) max_cycles_o <= cyc_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_lockin_mac_scheduler.sv
// tb_lockin_mac_scheduler
// Directed bench for lockin_mac_scheduler. The main instance uses the
// default MAC_LATENCY of 2; a second instance is built with MAC_LATENCY=0.
// Cycle c counts from the cycle in which tick_i is high (c = 0).
module tb_lockin_mac_scheduler;

  localparam int NCH = 5;
  localparam int TW  = 7;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            tick  = 1'b0;
  logic [NCH-1:0]  en    = '0;
  logic [NCH*TW-1:0] taps = '0;
  logic [NCH-1:0]  grant, done;
  logic [TW-1:0]   tap_idx;
  logic            valid, clear, last, busy, overrun;

  logic            tick_z = 1'b0;
  logic [NCH-1:0]  en_z   = '0;
  logic [NCH*TW-1:0] taps_z = {5{7'd1}};
  logic [NCH-1:0]  grant_z, done_z;
  logic [TW-1:0]   tap_idx_z;
  logic            valid_z, clear_z, last_z, busy_z, overrun_z;
`ifdef LOCKIN_SCHED_STATS_EN
  logic [15:0]     max_cyc, max_cyc_z;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lockin_mac_scheduler dut (
    .clk_i(clk), .reset_ni(rst_n), .tick_i(tick), .en_i(en), .taps_i(taps),
    .grant_o(grant), .tap_idx_o(tap_idx), .mac_valid_o(valid),
    .mac_clear_o(clear), .mac_last_o(last), .done_o(done),
    .busy_o(busy), .overrun_o(overrun)
`ifdef LOCKIN_SCHED_STATS_EN
    , .max_cycles_o(max_cyc)
`endif
  );

  lockin_mac_scheduler #(.MAC_LATENCY(0)) dut_z (
    .clk_i(clk), .reset_ni(rst_n), .tick_i(tick_z), .en_i(en_z), .taps_i(taps_z),
    .grant_o(grant_z), .tap_idx_o(tap_idx_z), .mac_valid_o(valid_z),
    .mac_clear_o(clear_z), .mac_last_o(last_z), .done_o(done_z),
    .busy_o(busy_z), .overrun_o(overrun_z)
`ifdef LOCKIN_SCHED_STATS_EN
    , .max_cycles_o(max_cyc_z)
`endif
  );

  task automatic start_tick(input logic [NCH-1:0] e);
    @(posedge clk); #1;
    tick = 1'b1;
    en   = e;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++; if (grant !== 5'b0) begin bad++; $display("FAIL reset_grant got=%b want=0", grant); end
    total++; if (done !== 5'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (tap_idx !== 7'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", tap_idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (busy_z !== 1'b0) begin bad++; $display("FAIL reset_busy_z got=%b want=0", busy_z); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy); end
  endtask

  // Channels 0, 2, 4 with 61/23/23 taps: each costs taps+4 cycles, so done
  // lands at 1+64=65, 66+26=92, 93+26=119 and busy drops at 120.
  task automatic test_round_robin();
    logic [NCH-1:0] exp_vec [3];
    int             exp_cyc [3];
    logic [NCH-1:0] got_vec [3];
    int             got_cyc [3];
    logic [NCH-1:0] g1;
    int n_done, n_valid, c;
    exp_vec = '{5'b00001, 5'b00100, 5'b10000};
    exp_cyc = '{65, 92, 119};
    got_vec = '{default: '0};
    got_cyc = '{default: 0};
    n_done = 0; n_valid = 0; c = 0;
    taps = {7'd23, 7'd0, 7'd23, 7'd0, 7'd61};
    start_tick(5'b10101);
    while (c < 400) begin
      @(negedge clk);
      if (valid) n_valid++;
      if (done != '0) begin
        if (n_done < 3) begin got_vec[n_done] = done; got_cyc[n_done] = c; end
        n_done++;
      end
      if (c > 0 && !busy) break;
      @(posedge clk); #1; tick = 1'b0; c++;
    end
    total++; if (n_done != 3) begin bad++; $display("FAIL rr_done_count got=%0d want=3", n_done); end
    for (int i = 0; i < 3; i++) begin
      total++; if (got_vec[i] !== exp_vec[i]) begin bad++; $display("FAIL rr_order[%0d] got=%b want=%b", i, got_vec[i], exp_vec[i]); end
      total++; if (got_cyc[i] != exp_cyc[i]) begin bad++; $display("FAIL rr_done_cycle[%0d] got=%0d want=%0d", i, got_cyc[i], exp_cyc[i]); end
    end
    total++; if (n_valid != 107) begin bad++; $display("FAIL rr_valid_cycles got=%0d want=107", n_valid); end
    total++; if (c != 120) begin bad++; $display("FAIL rr_idle_cycle got=%0d want=120", c); end
    // Pointer must have wrapped back to 0: channel 0 wins over channel 4.
    n_done = 0; c = 0; g1 = '0;
    start_tick(5'b10001);
    while (c < 400) begin
      @(negedge clk);
      if (c == 1) g1 = grant;
      if (done != '0 && n_done == 0) begin got_vec[0] = done; got_cyc[0] = c; n_done++; end
      if (c > 0 && !busy) break;
      @(posedge clk); #1; tick = 1'b0; c++;
    end
    total++; if (g1 !== 5'b00001) begin bad++; $display("FAIL rr_ptr_wrap got=%b want=00001", g1); end
    total++; if (got_cyc[0] != 65) begin bad++; $display("FAIL rr_wrap_done_cycle got=%0d want=65", got_cyc[0]); end
    total++; if (c != 93) begin bad++; $display("FAIL rr_wrap_idle got=%0d want=93", c); end
  endtask

  // Channel 0 with 3 taps: ARB 1, RUN 2-4, DRAIN 5-6, DONE 7, idle 8.
  // en is held at all-ones after the tick and must be ignored.
  task automatic test_single();
    logic e_valid, e_clear, e_last, e_busy;
    logic [TW-1:0]  e_idx;
    logic [NCH-1:0] e_grant, e_done;
    taps = {7'd0, 7'd0, 7'd0, 7'd0, 7'd3};
    start_tick(5'b00001);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      e_valid = (c >= 2 && c <= 4);
      e_idx   = e_valid ? TW'(c - 2) : 7'd0;
      e_clear = (c == 2);
      e_last  = (c == 4);
      e_busy  = (c >= 1 && c <= 7);
      e_grant = e_busy ? 5'b00001 : 5'b00000;
      e_done  = (c == 7) ? 5'b00001 : 5'b00000;
      total++; if (valid !== e_valid) begin bad++; $display("FAIL single_valid c=%0d got=%b want=%b", c, valid, e_valid); end
      total++; if (tap_idx !== e_idx) begin bad++; $display("FAIL single_idx c=%0d got=%0d want=%0d", c, tap_idx, e_idx); end
      total++; if (clear !== e_clear) begin bad++; $display("FAIL single_clear c=%0d got=%b want=%b", c, clear, e_clear); end
      total++; if (last !== e_last) begin bad++; $display("FAIL single_last c=%0d got=%b want=%b", c, last, e_last); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL single_busy c=%0d got=%b want=%b", c, busy, e_busy); end
      total++; if (grant !== e_grant) begin bad++; $display("FAIL single_grant c=%0d got=%b want=%b", c, grant, e_grant); end
      total++; if (done !== e_done) begin bad++; $display("FAIL single_done c=%0d got=%b want=%b", c, done, e_done); end
      @(posedge clk); #1; tick = 1'b0; en = 5'b11111;
    end
  endtask

  // Channel 1 with zero taps: ARB 1, DONE 2, no MAC activity.
  task automatic test_zero_taps();
    logic [NCH-1:0] e_grant, e_done;
    taps = {7'd0, 7'd0, 7'd0, 7'd0, 7'd3};
    start_tick(5'b00010);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      e_grant = (c == 1 || c == 2) ? 5'b00010 : 5'b00000;
      e_done  = (c == 2) ? 5'b00010 : 5'b00000;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL zero_valid c=%0d got=%b want=0", c, valid); end
      total++; if (grant !== e_grant) begin bad++; $display("FAIL zero_grant c=%0d got=%b want=%b", c, grant, e_grant); end
      total++; if (done !== e_done) begin bad++; $display("FAIL zero_done c=%0d got=%b want=%b", c, done, e_done); end
      @(posedge clk); #1; tick = 1'b0;
    end
  endtask

  // All channels at 61 taps (65 cycles each), pointer starts at 2. The
  // second tick at cycle 100 lands during channel 3, re-queueing 2 and 3:
  // order 2,3,4,0,1,2,3 with done at 65*k, busy low at 456.
  task automatic test_overrun();
    int exp_ch [7];
    int got_ch [7];
    int n_done, c, last_cyc;
    logic ov100, ov101;
    exp_ch = '{2, 3, 4, 0, 1, 2, 3};
    got_ch = '{default: -1};
    n_done = 0; c = 0; last_cyc = 0; ov100 = 1'bx; ov101 = 1'bx;
    taps = {5{7'd61}};
    start_tick(5'b11111);
    while (c < 800) begin
      @(negedge clk);
      if (c == 100) ov100 = overrun;
      if (c == 101) ov101 = overrun;
      if (done != '0) begin
        if (n_done < 7) begin
          for (int k = 0; k < NCH; k++) if (done[k]) got_ch[n_done] = k;
        end
        n_done++;
        last_cyc = c;
      end
      if (c > 0 && !busy) break;
      @(posedge clk); #1; tick = (c + 1 == 100); c++;
    end
    total++; if (ov100 !== 1'b0) begin bad++; $display("FAIL overrun_before got=%b want=0", ov100); end
    total++; if (ov101 !== 1'b1) begin bad++; $display("FAIL overrun_after got=%b want=1", ov101); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
    total++; if (n_done != 7) begin bad++; $display("FAIL overrun_done_count got=%0d want=7", n_done); end
    for (int i = 0; i < 7; i++) begin
      total++; if (got_ch[i] != exp_ch[i]) begin bad++; $display("FAIL overrun_order[%0d] got=%0d want=%0d", i, got_ch[i], exp_ch[i]); end
    end
    total++; if (last_cyc != 455) begin bad++; $display("FAIL overrun_last_done got=%0d want=455", last_cyc); end
    total++; if (c != 456) begin bad++; $display("FAIL overrun_idle got=%0d want=456", c); end
  endtask

  // Channel 0 is running (pointer was 4, wraps to 0) with 1 and 2 still
  // queued; reset at tap 10 must clear everything, including the pointer.
  task automatic test_reset_mid_run();
    int c, first_cyc;
    logic [NCH-1:0] g1;
    taps = {5{7'd61}};
    start_tick(5'b00111);
    repeat (12) begin @(posedge clk); #1; tick = 1'b0; end
    @(negedge clk);
    total++; if (tap_idx !== 7'd10) begin bad++; $display("FAIL midrun_idx got=%0d want=10", tap_idx); end
    rst_n = 1'b0;
    #1;
    total++; if (grant !== 5'b0) begin bad++; $display("FAIL midrun_grant got=%b want=0", grant); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL midrun_valid got=%b want=0", valid); end
    total++; if (tap_idx !== 7'd0) begin bad++; $display("FAIL midrun_tapidx got=%0d want=0", tap_idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrun_busy got=%b want=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midrun_overrun got=%b want=0", overrun); end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrun_pending got=%b want=0", busy); end
    c = 0; g1 = '0; first_cyc = -1;
    start_tick(5'b10001);
    while (c < 400) begin
      @(negedge clk);
      if (c == 1) g1 = grant;
      if (done != '0 && first_cyc < 0) first_cyc = c;
      if (c > 0 && !busy) break;
      @(posedge clk); #1; tick = 1'b0; c++;
    end
    total++; if (g1 !== 5'b00001) begin bad++; $display("FAIL midrun_restart_grant got=%b want=00001", g1); end
    total++; if (first_cyc != 65) begin bad++; $display("FAIL midrun_first_done got=%0d want=65", first_cyc); end
    total++; if (c != 131) begin bad++; $display("FAIL midrun_idle got=%0d want=131", c); end
  endtask

  // MAC_LATENCY=0 instance, channel 0 with 1 tap: ARB 1, RUN 2, DONE 3.
  task automatic test_lat0();
    logic e_run, e_busy;
    logic [NCH-1:0] e_done;
    @(posedge clk); #1; tick_z = 1'b1; en_z = 5'b00001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e_run  = (c == 2);
      e_busy = (c >= 1 && c <= 3);
      e_done = (c == 3) ? 5'b00001 : 5'b00000;
      total++; if (valid_z !== e_run) begin bad++; $display("FAIL lat0_valid c=%0d got=%b want=%b", c, valid_z, e_run); end
      total++; if (clear_z !== e_run) begin bad++; $display("FAIL lat0_clear c=%0d got=%b want=%b", c, clear_z, e_run); end
      total++; if (last_z !== e_run) begin bad++; $display("FAIL lat0_last c=%0d got=%b want=%b", c, last_z, e_run); end
      total++; if (done_z !== e_done) begin bad++; $display("FAIL lat0_done c=%0d got=%b want=%b", c, done_z, e_done); end
      total++; if (busy_z !== e_busy) begin bad++; $display("FAIL lat0_busy c=%0d got=%b want=%b", c, busy_z, e_busy); end
`ifdef LOCKIN_SCHED_STATS_EN
      if (c == 5) begin
        total++; if (max_cyc_z !== 16'd4) begin bad++; $display("FAIL lat0_max_cycles got=%0d want=4", max_cyc_z); end
      end
`endif
      @(posedge clk); #1; tick_z = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_taps();
    test_overrun();
    test_reset_mid_run();
    test_lat0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
